// File: rtl/uart_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// uart_cmd_dispatch
//
// Decodes command frames received by the UART core and drives the AES
// encryption core. Holds the AES key and plaintext registers, pulses the AES
// load request, captures the ciphertext, and builds fixed-width response
// frames for the UART transmit path.
//
// Frame layout: byte0 = command, byte FRAME_BYTES-1 = check byte (must equal
// the command), bytes 16..1 = 128-bit payload.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_frame    received frame, byte0 in bits [7:0]
//   rx_valid    one-cycle strobe marking a new complete frame
//   aes_done    AES core done (level)
//   aes_result  AES ciphertext, valid while aes_done is high
//   aes_key     key register driven to the AES core
//   aes_text    plaintext register driven to the AES core
//   aes_ld      AES load request, held for LD_CYCLES cycles
//   tx_data     response frame to the UART transmitter
//   tx_send     one-cycle transmit trigger
//   tx_busy     UART transmitter busy
//   busy        high whenever the FSM is not idle
//   err_count   saturating count of rejected frames
// ---------------------------------------------------------------------------
module uart_cmd_dispatch #(
  parameter int           FRAME_BYTES = 18,
  parameter int           LD_CYCLES   = 2,
  parameter int           AES_TIMEOUT = 1024,
  parameter logic [127:0] KEY_INIT    = 128'h0,
  parameter logic [127:0] TEXT_INIT   = 128'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8*FRAME_BYTES-1:0] rx_frame,
  input  logic                     rx_valid,
  input  logic                     aes_done,
  input  logic [127:0]             aes_result,
  output logic [127:0]             aes_key,
  output logic [127:0]             aes_text,
  output logic                     aes_ld,
  output logic [8*FRAME_BYTES-1:0] tx_data,
  output logic                     tx_send,
  input  logic                     tx_busy,
  output logic                     busy,
  output logic [7:0]               err_count
);

  localparam int FW     = 8 * FRAME_BYTES;
  localparam int LD_W   = $clog2(LD_CYCLES + 1);
  localparam int WAIT_W = $clog2(AES_TIMEOUT + 1);

  localparam logic [7:0] CMD_NUM    = 8'h41;  // 'A'
  localparam logic [7:0] CMD_KEY    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_TEXT   = 8'h44;  // 'D'
  localparam logic [7:0] CMD_ENC    = 8'h45;  // 'E'
  localparam logic [7:0] CMD_RESULT = 8'h40;  // '@'
  localparam logic [7:0] CMD_RDKEY  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_RDTEXT = 8'h62;  // 'b'

  // Response strings are right-aligned: last character lands in byte0 and the
  // unused upper bytes are zero.
  localparam logic [FW-1:0] RSP_NUM     = FW'("123456789012345678");
  localparam logic [FW-1:0] RSP_KEY     = FW'("key updated");
  localparam logic [FW-1:0] RSP_TEXT    = FW'("plaintext updated");
  localparam logic [FW-1:0] RSP_ERR_FRM = FW'("ERR frame");
  localparam logic [FW-1:0] RSP_ERR_CMD = FW'("ERR cmd");
  localparam logic [FW-1:0] RSP_ERR_TMO = FW'("ERR timeout");

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    AES_LD,
    AES_WAIT,
    TX_WAIT,
    TX_PULSE
  } state_t;

  state_t              state, state_next;
  logic [FW-1:0]       frame_reg, frame_next;
  logic [FW-1:0]       response, resp_next;
  logic [FW-1:0]       tx_data_next;
  logic [127:0]        result_reg, result_next;
  logic [127:0]        key_next, text_next;
  logic [LD_W-1:0]     ld_cnt, ld_cnt_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic [7:0]          err_next;
  logic [8:0]          err_sum;
  logic                drop_err, fsm_err;
  logic [7:0]          cmd, chk;
  logic [127:0]        payload;

  assign cmd     = frame_reg[7:0];
  assign chk     = frame_reg[FW-1 -: 8];
  assign payload = frame_reg[135:8];

  // Next-state and datapath logic. Every register's next value defaults to
  // its current value so each state only spells out what it changes. A frame
  // arriving while the FSM is busy is dropped and counted as an error; it can
  // coincide with a decode error, so the error counter may step by two.
  always_comb begin
    state_next    = state;
    frame_next    = frame_reg;
    key_next      = aes_key;
    text_next     = aes_text;
    result_next   = result_reg;
    resp_next     = response;
    tx_data_next  = tx_data;
    ld_cnt_next   = ld_cnt;
    wait_cnt_next = wait_cnt;
    fsm_err       = 1'b0;
    aes_ld        = 1'b0;
    tx_send       = 1'b0;
    busy          = (state != IDLE);
    drop_err      = rx_valid && (state != IDLE);

    case (state)
      IDLE: begin
        if (rx_valid) begin
          frame_next = rx_frame;
          state_next = DECODE;
        end
      end

      DECODE: begin
        state_next = TX_WAIT;
        if (chk != cmd) begin
          resp_next = RSP_ERR_FRM;
          fsm_err   = 1'b1;
        end else begin
          case (cmd)
            CMD_NUM:    resp_next = RSP_NUM;
            CMD_KEY: begin
              key_next  = payload;
              resp_next = RSP_KEY;
            end
            CMD_TEXT: begin
              text_next = payload;
              resp_next = RSP_TEXT;
            end
            CMD_ENC: begin
              ld_cnt_next = '0;
              state_next  = AES_LD;
            end
            CMD_RESULT: resp_next = FW'(result_reg);
            CMD_RDKEY:  resp_next = FW'(aes_key);
            CMD_RDTEXT: resp_next = FW'(aes_text);
            default: begin
              resp_next = RSP_ERR_CMD;
              fsm_err   = 1'b1;
            end
          endcase
        end
      end

      // Load is stretched so a half-rate AES clock is guaranteed to see it.
      AES_LD: begin
        aes_ld = 1'b1;
        if (ld_cnt == LD_W'(LD_CYCLES - 1)) begin
          wait_cnt_next = '0;
          state_next    = AES_WAIT;
        end else begin
          ld_cnt_next = ld_cnt + LD_W'(1);
        end
      end

      // aes_done still high from a previous run is accepted as done.
      AES_WAIT: begin
        if (wait_cnt == WAIT_W'(AES_TIMEOUT)) begin
          resp_next  = RSP_ERR_TMO;
          fsm_err    = 1'b1;
          state_next = TX_WAIT;
        end else if (aes_done) begin
          result_next = aes_result;
          resp_next   = FW'(aes_result);
          state_next  = TX_WAIT;
        end else begin
          wait_cnt_next = wait_cnt + WAIT_W'(1);
        end
      end

      TX_WAIT: begin
        if (!tx_busy) begin
          tx_data_next = response;
          state_next   = TX_PULSE;
        end
      end

      TX_PULSE: begin
        tx_send    = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase

    err_sum  = {1'b0, err_count} + {8'd0, drop_err} + {8'd0, fsm_err};
    err_next = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // State and datapath registers. Reset wins in every state, which abandons
  // any in-flight AES wait or pending transmit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      frame_reg  <= '0;
      aes_key    <= KEY_INIT;
      aes_text   <= TEXT_INIT;
      result_reg <= '0;
      response   <= '0;
      tx_data    <= '0;
      ld_cnt     <= '0;
      wait_cnt   <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_next;
      frame_reg  <= frame_next;
      aes_key    <= key_next;
      aes_text   <= text_next;
      result_reg <= result_next;
      response   <= resp_next;
      tx_data    <= tx_data_next;
      ld_cnt     <= ld_cnt_next;
      wait_cnt   <= wait_cnt_next;
      err_count  <= err_next;
    end
  end

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_dispatch
//
// Self-checking bench for uart_cmd_dispatch. A command-level reference model
// predicts each response frame and the error count; expected frames go into
// a scoreboard queue that a monitor drains whenever tx_send is seen. A simple
// AES stand-in answers load requests after a programmable delay.
// ---------------------------------------------------------------------------
module tb_uart_cmd_dispatch;

  localparam int           FW          = 144;
  localparam int           AES_TIMEOUT = 1024;
  localparam logic [127:0] KEY_INIT    = 128'h0;
  localparam logic [127:0] TEXT_INIT   = 128'h0;

  logic           clk = 1'b0;
  logic           reset;
  logic [FW-1:0]  rx_frame;
  logic           rx_valid;
  logic           aes_done;
  logic [127:0]   aes_result;
  logic [127:0]   aes_key;
  logic [127:0]   aes_text;
  logic           aes_ld;
  logic [FW-1:0]  tx_data;
  logic           tx_send;
  logic           tx_busy;
  logic           busy;
  logic [7:0]     err_count;

  uart_cmd_dispatch dut (
    .clk        (clk),
    .reset      (reset),
    .rx_frame   (rx_frame),
    .rx_valid   (rx_valid),
    .aes_done   (aes_done),
    .aes_result (aes_result),
    .aes_key    (aes_key),
    .aes_text   (aes_text),
    .aes_ld     (aes_ld),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int n_checks = 0;
  int n_fails  = 0;
  int send_count = 0;
  int last_send_cycle = 0;
  int rx_cycle = 0;

  logic [FW-1:0] sb_q[$];

  // Reference model state
  logic [127:0] m_key, m_text, m_result;
  int           m_err;

  // AES stand-in controls
  bit           aes_en = 1'b0;
  logic [127:0] aes_val;
  int           aes_delay = 10;
  int           aes_hold  = 2;

  task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                             input logic [FW-1:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [FW-1:0] str2frame(input string s);
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[FW-9:0], s[i]};
    return r;
  endfunction

  function automatic logic [FW-1:0] mkFrame(input logic [7:0] c, input logic [7:0] k,
                                            input logic [127:0] pl);
    return {k, pl, c};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [FW-1:0] randFrame();
    logic [FW-1:0] r;
    r = '0;
    for (int i = 0; i < 5; i++) r = {r[FW-33:0], $urandom()};
    return r;
  endfunction

  function automatic void bumpErr();
    m_err = (m_err >= 255) ? 255 : m_err + 1;
  endfunction

  // Command-level model: decide the response from the frame contents alone.
  task automatic modelFrame(input logic [FW-1:0] f, output bit is_e);
    logic [7:0]    c, k;
    logic [127:0]  pl;
    logic [FW-1:0] exp;
    c    = f[7:0];
    k    = f[FW-1 -: 8];
    pl   = f[135:8];
    is_e = 1'b0;
    if (k != c) begin
      exp = str2frame("ERR frame");
      bumpErr();
    end else begin
      case (c)
        8'h41: exp = str2frame("123456789012345678");
        8'h43: begin m_key = pl;  exp = str2frame("key updated"); end
        8'h44: begin m_text = pl; exp = str2frame("plaintext updated"); end
        8'h45: begin
          is_e = 1'b1;
          if (aes_en) begin
            m_result = aes_val;
            exp      = FW'(aes_val);
          end else begin
            exp = str2frame("ERR timeout");
            bumpErr();
          end
        end
        8'h40: exp = FW'(m_result);
        8'h61: exp = FW'(m_key);
        8'h62: exp = FW'(m_text);
        default: begin
          exp = str2frame("ERR cmd");
          bumpErr();
        end
      endcase
    end
    sb_q.push_back(exp);
  endtask

  task automatic applyStimulus(input logic [FW-1:0] f);
    @(negedge clk);
    rx_frame = f;
    rx_valid = 1'b1;
    rx_cycle = cycle;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_frame = randFrame();
  endtask

  task automatic waitDone(input int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL wait_timeout: %0d responses still pending after %0d cycles, required 0",
               sb_q.size(), budget);
      sb_q.delete();
    end
  endtask

  task automatic runFrame(input logic [FW-1:0] f);
    bit is_e;
    modelFrame(f, is_e);
    applyStimulus(f);
    waitDone(AES_TIMEOUT + 200);
    if (!is_e && !tx_busy)
      checkOutput("latency", FW'(last_send_cycle - rx_cycle), FW'(3));
    checkOutput("err_count", FW'(err_count), FW'(m_err));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_aes_key"},   FW'(aes_key),   FW'(KEY_INIT));
    checkOutput({tag, "_aes_text"},  FW'(aes_text),  FW'(TEXT_INIT));
    checkOutput({tag, "_aes_ld"},    FW'(aes_ld),    FW'(0));
    checkOutput({tag, "_tx_send"},   FW'(tx_send),   FW'(0));
    checkOutput({tag, "_tx_data"},   tx_data,        FW'(0));
    checkOutput({tag, "_err_count"}, FW'(err_count), FW'(0));
    checkOutput({tag, "_busy"},      FW'(busy),      FW'(0));
  endtask

  task automatic doReset(input string tag);
    int sends;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues(tag);
    reset    = 1'b0;
    sb_q.delete();
    m_key    = KEY_INIT;
    m_text   = TEXT_INIT;
    m_result = '0;
    m_err    = 0;
    sends    = send_count;
    tx_busy  = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput({tag, "_no_send"}, FW'(send_count), FW'(sends));
  endtask

  // Monitor: every tx_send pops one expected frame; the cycle after a send
  // the block must be idle again.
  bit prev_send = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_send = 1'b0;
    end else begin
      if (prev_send) checkOutput("busy_after_send", FW'(busy), FW'(0));
      prev_send = tx_send;
      if (tx_send) begin
        send_count++;
        last_send_cycle = cycle;
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_send: got tx_data %h, expected no transmit", tx_data);
        end else begin
          checkOutput("tx_data", tx_data, sb_q.pop_front());
        end
      end
    end
  end

  // Measures every aes_ld pulse width.
  int ld_run = 0;
  always @(negedge clk) begin
    if (reset) begin
      ld_run = 0;
    end else if (aes_ld) begin
      ld_run++;
    end else if (ld_run != 0) begin
      checkOutput("aes_ld_len", FW'(ld_run), FW'(2));
      ld_run = 0;
    end
  end

  // AES stand-in: answers a load aes_delay cycles later, holding done for
  // aes_hold cycles with the prepared result.
  initial begin
    aes_done   = 1'b0;
    aes_result = '0;
    forever begin
      @(negedge clk);
      if (aes_ld && aes_en && !reset) begin
        repeat (aes_delay) @(negedge clk);
        aes_done   = 1'b1;
        aes_result = aes_val;
        repeat (aes_hold) @(negedge clk);
        aes_done   = 1'b0;
        aes_result = rand128();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: directed scenarios first, then randomized commands,
  // reset-abort cases and error-counter saturation.
  initial begin
    int            elapsed, b, sends;
    logic [127:0]  pl;
    logic [7:0]    c, k;
    int            kind;

    reset    = 1'b1;
    rx_frame = '0;
    rx_valid = 1'b0;
    tx_busy  = 1'b0;
    aes_val  = '0;
    m_key    = KEY_INIT;
    m_text   = TEXT_INIT;
    m_result = '0;
    m_err    = 0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    reset = 1'b0;

    $display("[TB] echo frame");
    runFrame(mkFrame(8'h41, 8'h41, 128'h0));

    $display("[TB] key write and readback");
    pl = 128'h000102030405060708090a0b0c0d0e0f;
    runFrame(mkFrame(8'h43, 8'h43, pl));
    checkOutput("aes_key_after_C", FW'(aes_key), FW'(pl));
    runFrame(mkFrame(8'h61, 8'h61, rand128()));

    $display("[TB] encrypt with known key and text");
    runFrame(mkFrame(8'h43, 8'h43, 128'hf34481ec3cc627bacd5dc3fb08f273e6));
    runFrame(mkFrame(8'h44, 8'h44, 128'h0336763e966d92595a567cc9ce537f5e));
    checkOutput("aes_text_after_D", FW'(aes_text), FW'(128'h0336763e966d92595a567cc9ce537f5e));
    aes_en    = 1'b1;
    aes_delay = 10;
    aes_hold  = 3;
    aes_val   = rand128();
    runFrame(mkFrame(8'h45, 8'h45, rand128()));
    runFrame(mkFrame(8'h40, 8'h40, rand128()));

    $display("[TB] bad check byte and unknown command");
    runFrame(mkFrame(8'h41, 8'h42, 128'h0));
    runFrame(mkFrame(8'h5A, 8'h5A, 128'h0));
    checkOutput("err_count_two", FW'(err_count), FW'(2));

    $display("[TB] transmitter busy holds off tx_send");
    tx_busy = 1'b1;
    begin
      bit is_e;
      modelFrame(mkFrame(8'h41, 8'h41, rand128()), is_e);
    end
    sends = send_count;
    applyStimulus(mkFrame(8'h41, 8'h41, 128'h0));
    repeat (50) @(negedge clk);
    checkOutput("no_send_while_busy", FW'(send_count), FW'(sends));
    tx_busy = 1'b0;
    b = cycle;
    waitDone(100);
    checkOutput("send_after_busy", FW'(last_send_cycle - b), FW'(1));

    $display("[TB] AES timeout with dropped frame");
    aes_en = 1'b0;
    begin
      bit is_e;
      modelFrame(mkFrame(8'h45, 8'h45, 128'h0), is_e);
    end
    applyStimulus(mkFrame(8'h45, 8'h45, 128'h0));
    b = rx_cycle;
    repeat (100) @(negedge clk);
    applyStimulus(mkFrame(8'h41, 8'h41, 128'h0));
    bumpErr();
    waitDone(AES_TIMEOUT + 200);
    elapsed = last_send_cycle - b;
    checkOutput("timeout_latency_ok",
                FW'(elapsed >= AES_TIMEOUT && elapsed <= AES_TIMEOUT + 10), FW'(1));
    checkOutput("err_count_timeout", FW'(err_count), FW'(m_err));

    $display("[TB] randomized commands");
    aes_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      kind      = $urandom_range(0, 8);
      aes_delay = $urandom_range(2, 20);
      aes_hold  = $urandom_range(1, 4);
      aes_val   = rand128();
      pl        = rand128();
      case (kind)
        0: c = 8'h41;
        1: c = 8'h43;
        2: c = 8'h44;
        3: c = 8'h45;
        4: c = 8'h40;
        5: c = 8'h61;
        6: c = 8'h62;
        default: begin
          do c = 8'($urandom_range(0, 255));
          while (c inside {8'h40, 8'h41, 8'h43, 8'h44, 8'h45, 8'h61, 8'h62});
        end
      endcase
      k = c;
      if (kind == 8) k = c ^ 8'($urandom_range(1, 255));
      runFrame(mkFrame(c, k, pl));
    end

    $display("[TB] reset during AES wait");
    runFrame(mkFrame(8'h43, 8'h43, rand128() | 128'h1));
    aes_en = 1'b0;
    applyStimulus(mkFrame(8'h45, 8'h45, 128'h0));
    repeat (20) @(negedge clk);
    doReset("rst_aes_wait");
    runFrame(mkFrame(8'h40, 8'h40, 128'h0));

    $display("[TB] reset during transmit wait");
    runFrame(mkFrame(8'h44, 8'h44, rand128() | 128'h1));
    tx_busy = 1'b1;
    applyStimulus(mkFrame(8'h41, 8'h41, 128'h0));
    repeat (5) @(negedge clk);
    doReset("rst_tx_wait");

    $display("[TB] error counter saturation");
    for (int i = 0; i < 260; i++) runFrame(mkFrame(8'h5A, 8'h5A, 128'h0));
    checkOutput("err_count_saturated", FW'(err_count), FW'(8'hFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
